// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the maskable interrupt controller: register map,
// request state encoding, default configuration and an index-width helper.
package irq_ctrl_pkg;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_VBASE = 2'd1;
    localparam logic [1:0] REG_MODE  = 2'd2;
    localparam logic [1:0] REG_PEND  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    localparam int         DEF_NUM_SRC   = 8;
    localparam int         DEF_VEC_W     = 9;
    localparam int         DEF_VEC_SHIFT = 3;
    localparam logic [8:0] DEF_VEC_BASE  = 9'h080;
    localparam logic [7:0] DEF_MASK      = 8'hFF;

    // Index width that stays at least one bit for single-source builds.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: valid when any request is set, index of
// the lowest set request otherwise zero.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid_o = |req_i;
        idx_o   = {IDX_W{1'b0}};
        for (int i = W - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? IDX_W'(i) : idx_o;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised maskable interrupt controller with irq_rq/irq_ack handshake.
// Optional nested in-service tracking is enabled by IRQ_CTRL_INSERVICE_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int               NUM_SRC      = DEF_NUM_SRC,
    parameter int               VEC_W        = DEF_VEC_W,
    parameter int               VEC_SHIFT    = DEF_VEC_SHIFT,
    parameter logic [VEC_W-1:0] VEC_BASE_RST = VEC_W'(DEF_VEC_BASE),
    parameter logic [7:0]       MASK_RST     = DEF_MASK
) (
    input  logic               CLK_32M,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cs,
    input  logic               iowr,
    input  logic               iord,
    input  logic [1:0]         a,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               irq_rq,
    output logic [VEC_W-1:0]   irq_addr,
    input  logic               irq_ack
);

    localparam int IDX_W = idx_width(NUM_SRC);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] level_q, level_d;
    logic [NUM_SRC-1:0] src_prev_q;
    logic [VEC_W-1:0]   vbase_q, vbase_d;

    irq_state_e         state_q;
    logic               irq_rq_q;
    logic [VEC_W-1:0]   irq_addr_q;
    logic [IDX_W-1:0]   idx_q;

    logic               wr_s;
    logic               rd_s;
    logic               ack_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] floor_s;
    logic [NUM_SRC-1:0] cand_s;
    logic               win_valid_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [VEC_W-1:0]   addr_s;
    logic [7:0]         pend_rd_s;

    assign wr_s      = cs & iowr;
    assign rd_s      = cs & iord;
    assign ack_s     = (state_q == REQ) & irq_ack;
    assign ack_clr_s = ack_s ? (NUM_SRC'(1'b1) << idx_q) : {NUM_SRC{1'b0}};
    assign set_s     = src & ~src_prev_q;

`ifdef IRQ_CTRL_INSERVICE_EN
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [NUM_SRC-1:0] eoi_clr_s;
    logic               isr_valid_s;
    logic [IDX_W-1:0]   isr_idx_s;
    logic               eoi_s;

    irq_prio_enc #(
        .W     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_isr_enc (
        .req_i   (isr_q),
        .valid_o (isr_valid_s),
        .idx_o   (isr_idx_s)
    );

    // din[7] on the pending register selects EOI instead of W1C.
    assign eoi_s     = wr_s & (a == REG_PEND) & din[7];
    assign w1c_s     = (wr_s & (a == REG_PEND) & ~din[7]) ? NUM_SRC'(din) : {NUM_SRC{1'b0}};
    assign pend_rd_s = {1'b1, 7'(pending_q)};

    // Nesting floor and in-service bookkeeping.
    always_comb begin
        if (isr_valid_s) begin
            floor_s = (NUM_SRC'(1'b1) << isr_idx_s) - NUM_SRC'(1'b1);
        end else begin
            floor_s = {NUM_SRC{1'b1}};
        end
        if (eoi_s && isr_valid_s) begin
            eoi_clr_s = NUM_SRC'(1'b1) << isr_idx_s;
        end else begin
            eoi_clr_s = {NUM_SRC{1'b0}};
        end
        isr_d = (isr_q & ~eoi_clr_s) | ack_clr_s;
    end

    // In-service register.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            isr_q <= {NUM_SRC{1'b0}};
        end else begin
            isr_q <= isr_d;
        end
    end
`else
    assign floor_s   = {NUM_SRC{1'b1}};
    assign w1c_s     = (wr_s & (a == REG_PEND)) ? NUM_SRC'(din) : {NUM_SRC{1'b0}};
    assign pend_rd_s = 8'(pending_q);
`endif

    assign cand_s = pending_q & ~mask_q & floor_s;

    irq_prio_enc #(
        .W     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_win_enc (
        .req_i   (cand_s),
        .valid_o (win_valid_s),
        .idx_o   (win_idx_s)
    );

    assign addr_s = vbase_q + (VEC_W'(win_idx_s) << VEC_SHIFT);

    // Register write decode.
    always_comb begin
        mask_d  = mask_q;
        level_d = level_q;
        vbase_d = vbase_q;
        if (wr_s) begin
            case (a)
                REG_MASK:  mask_d  = NUM_SRC'(din);
                REG_VBASE: vbase_d = VEC_W'({din, 1'b0});
                REG_MODE:  level_d = NUM_SRC'(din);
                default:   mask_d  = mask_q;
            endcase
        end else begin
            mask_d  = mask_q;
            level_d = level_q;
            vbase_d = vbase_q;
        end
    end

    // Edge sources latch and a set beats any same-cycle clear; level sources follow src.
    always_comb begin
        pending_d = (level_q & src)
                  | (~level_q & (set_s | (pending_q & ~(w1c_s | ack_clr_s))));
    end

    // Programmable registers, pending bits and source history.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            pending_q  <= {NUM_SRC{1'b0}};
            mask_q     <= MASK_RST[NUM_SRC-1:0];
            level_q    <= {NUM_SRC{1'b0}};
            vbase_q    <= VEC_BASE_RST;
            src_prev_q <= src;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            level_q    <= level_d;
            vbase_q    <= vbase_d;
            src_prev_q <= src;
        end
    end

    // Request handshake; GAP arbitrates like IDLE so the low phase lasts one cycle.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            irq_rq_q   <= 1'b0;
            irq_addr_q <= VEC_BASE_RST;
            idx_q      <= {IDX_W{1'b0}};
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    if (win_valid_s) begin
                        state_q    <= REQ;
                        irq_rq_q   <= 1'b1;
                        idx_q      <= win_idx_s;
                        irq_addr_q <= addr_s;
                    end else begin
                        state_q    <= IDLE;
                        irq_rq_q   <= 1'b0;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state_q  <= GAP;
                        irq_rq_q <= 1'b0;
                    end else begin
                        irq_rq_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    irq_rq_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_rq   = irq_rq_q;
    assign irq_addr = irq_addr_q;

    // Read mux straight from the registers.
    always_comb begin
        dout = 8'h00;
        if (rd_s) begin
            case (a)
                REG_MASK:  dout = 8'(mask_q);
                REG_VBASE: dout = 8'(vbase_q >> 1);
                REG_MODE:  dout = 8'(level_q);
                default:   dout = pend_rd_s;
            endcase
        end else begin
            dout = 8'h00;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized checks of irq_ctrl in its default build; random rounds
// predict the delivered vector sequence from pulsed sources, mask and base.
module tb_irq_ctrl;

    logic       CLK_32M = 1'b0;
    logic       reset_n;
    logic [7:0] src;
    logic       cs, iowr, iord, irq_ack;
    logic [1:0] a;
    logic [7:0] din, dout;
    logic       irq_rq;
    logic [8:0] irq_addr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    irq_ctrl dut (
        .CLK_32M  (CLK_32M),
        .reset_n  (reset_n),
        .src      (src),
        .cs       (cs),
        .iowr     (iowr),
        .iord     (iord),
        .a        (a),
        .din      (din),
        .dout     (dout),
        .irq_rq   (irq_rq),
        .irq_addr (irq_addr),
        .irq_ack  (irq_ack)
    );

    always #5 CLK_32M = ~CLK_32M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_32M);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] d);
        cs = 1'b1; iowr = 1'b1; a = addr; din = d;
        tick();
        cs = 1'b0; iowr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [7:0] d);
        cs = 1'b1; iord = 1'b1; a = addr;
        #1;
        d = dout;
        cs = 1'b0; iord = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] s);
        src = s;
        tick();
        src = 8'h00;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_rq(input int max);
        int n;
        n = 0;
        while (irq_rq !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check("rq_wait", 32'(irq_rq), 32'd1);
    endtask

    initial begin
        logic [7:0] v, b, m, s;
        int         vb;
        int         exp_q[$];
        logic [8:0] ea;

        reset_n = 1'b0; src = 8'h00; cs = 1'b0; iowr = 1'b0; iord = 1'b0;
        irq_ack = 1'b0; a = 2'd0; din = 8'h00;
        repeat (3) tick();
        check("rst_rq", 32'(irq_rq), 32'd0);
        check("rst_addr", 32'(irq_addr), 32'h080);
        rd(2'd0, v); check("rst_mask", 32'(v), 32'hFF);
        rd(2'd1, v); check("rst_vbase", 32'(v), 32'h40);
        rd(2'd2, v); check("rst_mode", 32'(v), 32'h00);
        rd(2'd3, v); check("rst_pend", 32'(v), 32'h00);
        reset_n = 1'b1;
        tick();

        // single source, two-cycle latency
        wr(2'd0, 8'hFE);
        pulse(8'h01);
        check("t1_lat1", 32'(irq_rq), 32'd0);
        tick();
        check("t1_rq", 32'(irq_rq), 32'd1);
        check("t1_addr", 32'(irq_addr), 32'h080);
        ack();
        check("t1_gap", 32'(irq_rq), 32'd0);
        rd(2'd3, v); check("t1_pend", 32'(v), 32'h00);
        tick();

        // two sources, priority and one-cycle gap
        wr(2'd0, 8'hFC);
        pulse(8'h03);
        tick();
        check("t2_addr0", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h080});
        ack();
        check("t2_gap", 32'(irq_rq), 32'd0);
        tick();
        check("t2_addr1", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h088});
        ack();
        tick();
        check("t2_idle", 32'(irq_rq), 32'd0);

        // programmed vector base
        wr(2'd1, 8'h60);
        rd(2'd1, v); check("t3_vbase_rd", 32'(v), 32'h60);
        wr(2'd0, 8'hF7);
        pulse(8'h08);
        tick();
        check("t3_addr", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h0D8});
        ack();
        wr(2'd1, 8'h40);

        // level mode re-request, then drop
        wr(2'd0, 8'hFB);
        wr(2'd2, 8'h04);
        src = 8'h04;
        tick(); tick();
        check("t4_addr", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h090});
        ack();
        check("t4_gap", 32'(irq_rq), 32'd0);
        tick();
        check("t4_rereq", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h090});
        irq_ack = 1'b1; src = 8'h00;
        tick();
        irq_ack = 1'b0;
        tick();
        rd(2'd3, v); check("t4_pend", 32'(v), 32'h00);
        repeat (3) tick();
        check("t4_quiet", 32'(irq_rq), 32'd0);
        wr(2'd2, 8'h00);

        // masked source stays pending, then unmask
        wr(2'd0, 8'hFF);
        pulse(8'h20);
        tick(); tick();
        check("t5_masked", 32'(irq_rq), 32'd0);
        rd(2'd3, v); check("t5_pend", 32'(v), 32'h20);
        wr(2'd0, 8'hDF);
        tick();
        check("t5_addr", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h0A8});
        ack();
        tick();

        // W1C and edge on the same bit in the same cycle
        wr(2'd0, 8'hFF);
        src = 8'h02; cs = 1'b1; iowr = 1'b1; a = 2'd3; din = 8'h02;
        tick();
        cs = 1'b0; iowr = 1'b0; src = 8'h00;
        rd(2'd3, v); check("w1c_vs_edge", 32'(v), 32'h02);
        wr(2'd3, 8'h02);
        rd(2'd3, v); check("w1c_clear", 32'(v), 32'h00);

        // ack outside REQ is ignored
        pulse(8'h01);
        ack();
        rd(2'd3, v); check("idle_ack", 32'(v), 32'h01);
        wr(2'd3, 8'h01);

        // mask and W1C during REQ do not withdraw
        wr(2'd0, 8'hFE);
        pulse(8'h01);
        tick();
        wr(2'd0, 8'hFF);
        wr(2'd3, 8'h01);
        check("req_hold", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h080});
        ack();
        tick();
        check("req_after", 32'(irq_rq), 32'd0);

        // edge coincident with ack of the same source
        wr(2'd0, 8'hFE);
        pulse(8'h01);
        tick();
        check("t6_first", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h080});
        irq_ack = 1'b1; src = 8'h01;
        tick();
        irq_ack = 1'b0; src = 8'h00;
        check("t6_gap", 32'(irq_rq), 32'd0);
        rd(2'd3, v); check("t6_pend", 32'(v), 32'h01);
        tick();
        check("t6_second", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, 9'h080});
        ack();
        rd(2'd3, v); check("t6_done", 32'(v), 32'h00);
        tick();

        // reset during REQ loses the request
        pulse(8'h01);
        tick();
        check("mr_rq", 32'(irq_rq), 32'd1);
        reset_n = 1'b0;
        tick();
        check("mr_rst", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b0, 9'h080});
        reset_n = 1'b1;
        tick(); tick();
        check("mr_lost", 32'(irq_rq), 32'd0);

        // randomized rounds: expected vectors are the unmasked pulsed
        // sources in ascending order, each delivered exactly once
        for (int r = 0; r < 16; r++) begin
            b = 8'($urandom_range(0, 255));
            vb = int'(b) * 2;
            wr(2'd1, b);
            m = 8'($urandom);
            wr(2'd0, m);
            s = 8'($urandom_range(1, 255));
            src = s; tick(); src = 8'h00; tick();
            src = s; tick(); src = 8'h00; tick();
            exp_q.delete();
            for (int i = 0; i < 8; i++) begin
                if (s[i] && !m[i]) exp_q.push_back(i);
            end
            foreach (exp_q[k]) begin
                ea = 9'((vb + exp_q[k] * 8) % 512);
                wait_rq(8);
                check("rnd_addr", 32'(irq_addr), 32'(ea));
                repeat ($urandom_range(0, 3)) tick();
                check("rnd_hold", {23'd0, irq_rq, irq_addr}, {23'd0, 1'b1, ea});
                ack();
                check("rnd_gap", 32'(irq_rq), 32'd0);
            end
            repeat (3) tick();
            check("rnd_quiet", 32'(irq_rq), 32'd0);
            rd(2'd3, v); check("rnd_pend", 32'(v), 32'(s & m));
            wr(2'd3, 8'hFF);
            rd(2'd3, v); check("rnd_clr", 32'(v), 32'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised maskable interrupt controller for the V30 core. It generalises the fixed two-source VBLK/HINT request logic in the top level to NUM_SRC sources.
- Each source is latched into a pending bit on its edge or level, masked, then priority-resolved (lowest index wins). A vector is presented on an irq_rq/irq_ack handshake.
- Sits between video timing / sound / DMA event sources and the CPU irqrequest_in/irqvector_in/irqrequest_ack ports.
- The CPU programs it through the IO register bus, with chip select decoded externally from the IO PAL.

Parameters:
- NUM_SRC, 8, number of interrupt sources, 1..8.
- VEC_W, 9, width of irq_addr.
- VEC_SHIFT, 3, log2 spacing between consecutive source vectors.
- VEC_BASE_RST, 9'h080, reset value of the vector base register.
- MASK_RST, 8'hFF, reset mask; 1 = masked.

Ports:
- CLK_32M  in  1  system clock, all logic posedge.
- reset_n  in  1  synchronous, active-low reset.
- src  in  NUM_SRC  raw source levels, synchronous to CLK_32M.
- cs  in  1  register chip select.
- iowr  in  1  IO write strobe, single cycle.
- iord  in  1  IO read strobe.
- a  in  2  register address.
- din  in  8  write data.
- dout  out  8  read data, combinational from registers.
- irq_rq  out  1  interrupt request to CPU.
- irq_addr  out  VEC_W  vector for the current request.
- irq_ack  in  1  single-cycle CPU acknowledge.

Behaviour:
- Clocking and reset: one clock. reset_n is synchronous and active-low, sampled on posedge CLK_32M.
- Reset values:
  - irq_rq=0, irq_addr=VEC_BASE_RST.
  - pending=0, mask=MASK_RST, level_mode=0.
  - vbase=VEC_BASE_RST, src_d=src. Capturing src_d on reset prevents spurious edges after release.
  - State=IDLE.
- Registers (write when cs&iowr):
  - a=0: mask[NUM_SRC-1:0].
  - a=1: vbase[VEC_W-1:1] <= {din}, zero-extended, vbase[0]=0.
  - a=2: level_mode bits; 1 = level-sensitive.
  - a=3: write-1-to-clear pending bits.
- Reads (cs&iord): a=0 mask, a=1 vbase[8:1], a=2 level_mode, a=3 pending. Unused upper bits read 0.
- Source capture, per source i, each cycle:
  - Edge mode: pending[i] set when src[i]&~src_d[i].
  - Level mode: pending[i] = src[i], with no latching.
  - src_d <= src every cycle.
- Priority: candidates = pending & ~mask. The winner is the lowest set index.
- State machine:
  - IDLE: if candidates!=0, then irq_rq<=1, idx<=winner, irq_addr<=vbase+(winner<<VEC_SHIFT), truncated mod 2^VEC_W. Go to REQ. Latency from source edge to irq_rq is 2 cycles (1 to pending, 1 to request).
  - REQ: irq_rq held high and irq_addr stable until irq_ack. On irq_ack: irq_rq<=0, clear pending[idx] (edge mode only), go to GAP.
  - GAP: one cycle with irq_rq=0, then IDLE. This guarantees the CPU sees a deassertion between requests.
- Boundary rules:
  - Edge on src[idx] in the same cycle as the ack clear: set wins, pending stays 1, and it is re-requested after GAP.
  - Mask or W1C write during REQ does not withdraw the request. The vector is delivered once and the pending clear on ack is harmless.
  - irq_ack in IDLE/GAP is ignored.
  - Edges while pending is already set coalesce into one request.
  - Register write and edge on the same bit in the same cycle: the edge set wins over the W1C clear.
  - Reset asserted mid-REQ: irq_rq=0 on the next edge and the request is lost.

Optional Feature:
- Macro: IRQ_CTRL_INSERVICE_EN.
- Defined:
  - Adds an in-service register isr[NUM_SRC-1:0]; ack sets isr[idx].
  - Candidates are additionally limited to indices strictly below the lowest set isr bit, giving nested priority.
  - A write to a=3 with din[7]=1 is a non-specific EOI: it clears the lowest set isr bit, and pending is untouched.
  - Reads at a=3 return {isr-present flag=1, pending[6:0]}; this requires NUM_SRC<=7.
- Undefined: no isr and no nesting. a=3 is pure W1C and reads full pending.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register address constants REG_MASK=0, REG_VBASE=1, REG_MODE=2, REG_PEND=3;
  - state enum IDLE/REQ/GAP;
  - the default constants.
- Sub-module irq_prio_enc: parametrised lowest-set-bit priority encoder (valid + index). It is used for the winner and, with the feature, for the isr floor.

Test Plan:
- Reset, unmask src0 (write a=0 din=FE), pulse src[0] 1 cycle -> irq_rq=1 two cycles later, irq_addr=0x080; ack -> irq_rq=0, pending[0]=0.
- Unmask src0 and src1; raise src[1] then src[0] same cycle -> first vector 0x080. After ack plus GAP the second vector is 0x088, with irq_rq low for exactly 1 cycle between.
- Write vbase a=1 din=0x60, pulse src[3] unmasked -> irq_addr=0x0C0+0x18=0x0D8.
- Level mode on src2 held high, ack -> re-request 0x090 after GAP. Drop src2 -> pending[2]=0, no further request.
- Masked src5 pulsed -> no irq_rq, read a=3 shows 0x20. Unmask -> request 0x0A8 within 2 cycles.
- src0 edge coincident with ack of src0 -> pending[0] remains 1, second request 0x080 follows. With IRQ_CTRL_INSERVICE_EN, no second request until EOI write a=3 din=0x80.
